// File: rtl/tx_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tx_packet_arbiter
// Brief    : Packet-atomic round-robin arbiter that merges NUM_SRC
//            AXI4-Stream packet sources onto the single tx_packet path
//            feeding dest_packetizer. A granted source owns the output until
//            its tlast beat handshakes; one idle bubble separates packets.
// Revision : 1.0 - initial release
// ============================================================================
module tx_packet_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 8,
    parameter int TID_W   = 3
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [NUM_SRC-1:0]         src_enable,
    input  logic [NUM_SRC-1:0]         s_packet_tvalid,
    output logic [NUM_SRC-1:0]         s_packet_tready,
    input  logic [NUM_SRC*DATA_W-1:0]  s_packet_tdata,
    input  logic [NUM_SRC-1:0]         s_packet_tlast,
    input  logic [NUM_SRC*TID_W-1:0]   s_packet_tid,
    output logic                       tx_packet_tvalid,
    input  logic                       tx_packet_tready,
    output logic [DATA_W-1:0]          tx_packet_tdata,
    output logic                       tx_packet_tlast,
    output logic [TID_W-1:0]           tx_packet_tid,
    output logic [NUM_SRC-1:0]         grant,
    output logic                       busy
);

    // Pointer width; one extra bit is used while scanning so that
    // rr_ptr + offset never overflows before the explicit wrap.
    localparam int                   c_PTR_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [c_PTR_W:0]     c_NUM_EXT  = (c_PTR_W + 1)'(NUM_SRC);
    localparam logic [c_PTR_W-1:0]   c_LAST_IDX = c_PTR_W'(NUM_SRC - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t                 r_state;
    logic [c_PTR_W-1:0]     r_rr_ptr;
    logic [c_PTR_W-1:0]     r_gidx;
    logic [NUM_SRC-1:0]     r_grant;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t                 w_state_nxt;
    logic [c_PTR_W-1:0]     w_rr_ptr_nxt;
    logic [c_PTR_W-1:0]     w_gidx_nxt;
    logic [NUM_SRC-1:0]     w_grant_nxt;

    logic [NUM_SRC-1:0]     w_req;
    logic [c_PTR_W:0]       w_scan;
    logic                   w_sel_found;
    logic [c_PTR_W-1:0]     w_sel_idx;

    logic                   w_src_valid;
    logic [DATA_W-1:0]      w_src_data;
    logic                   w_src_last;
    logic [TID_W-1:0]       w_src_tid;

    // Only enabled sources take part in arbitration; the mask is looked at
    // solely when choosing a new owner, never during a packet.
    assign w_req = s_packet_tvalid & src_enable;

    // Rotating priority search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_scan      = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_scan = {1'b0, r_rr_ptr} + (c_PTR_W + 1)'(k);
            if (w_scan >= c_NUM_EXT) begin
                w_scan = w_scan - c_NUM_EXT;
            end
            if (!w_sel_found && w_req[w_scan[c_PTR_W-1:0]]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = w_scan[c_PTR_W-1:0];
            end
        end
    end

    // Select the granted source's beat signals (index held in r_gidx).
    always_comb begin
        w_src_valid = 1'b0;
        w_src_data  = '0;
        w_src_last  = 1'b0;
        w_src_tid   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_gidx == c_PTR_W'(i)) begin
                w_src_valid = s_packet_tvalid[i];
                w_src_data  = s_packet_tdata[i*DATA_W +: DATA_W];
                w_src_last  = s_packet_tlast[i];
                w_src_tid   = s_packet_tid[i*TID_W +: TID_W];
            end
        end
    end

    // Next-state logic and forwarding outputs for the IDLE/XFER machine.
    always_comb begin
        w_state_nxt      = r_state;
        w_rr_ptr_nxt     = r_rr_ptr;
        w_gidx_nxt       = r_gidx;
        w_grant_nxt      = r_grant;
        tx_packet_tvalid = 1'b0;
        tx_packet_tdata  = '0;
        tx_packet_tlast  = 1'b0;
        tx_packet_tid    = '0;
        s_packet_tready  = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_sel_found) begin
                    w_state_nxt = ST_XFER;
                    w_gidx_nxt  = w_sel_idx;
                    w_grant_nxt = NUM_SRC'(1) << w_sel_idx;
                end
            end

            ST_XFER: begin
                // Data fields are forced to zero while the owner has no
                // beat, so the output never shows stale payload.
                tx_packet_tvalid = w_src_valid;
                if (w_src_valid) begin
                    tx_packet_tdata = w_src_data;
                    tx_packet_tlast = w_src_last;
                    tx_packet_tid   = w_src_tid;
                end
                s_packet_tready = r_grant & {NUM_SRC{tx_packet_tready}};

                if (w_src_valid && tx_packet_tready && w_src_last) begin
                    w_state_nxt  = ST_IDLE;
                    w_grant_nxt  = '0;
                    w_rr_ptr_nxt = (r_gidx == c_LAST_IDX) ? '0 : r_gidx + 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_gidx   <= '0;
            r_grant  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_gidx   <= w_gidx_nxt;
            r_grant  <= w_grant_nxt;
        end
    end

    assign grant = r_grant;
    assign busy  = (r_state == ST_XFER);

endmodule
`default_nettype wire

// File: tb/tb_tx_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_packet_arbiter
// Brief    : Directed self-checking bench for tx_packet_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_packet_arbiter;

    logic        aclk;
    logic        aresetn;
    logic [3:0]  src_enable;
    logic [3:0]  s_packet_tvalid;
    logic [3:0]  s_packet_tready;
    logic [31:0] s_packet_tdata;
    logic [3:0]  s_packet_tlast;
    logic [11:0] s_packet_tid;
    logic        tx_packet_tvalid;
    logic        tx_packet_tready;
    logic [7:0]  tx_packet_tdata;
    logic        tx_packet_tlast;
    logic [2:0]  tx_packet_tid;
    logic [3:0]  grant;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    // Auto-source model: continuous packets of len[i] beats, data = i*16+beat
    logic [3:0] auto_on;
    int         beat [4];
    int         len  [4];

    int order_fair [5] = '{0, 1, 2, 3, 0};
    int order_mask [4] = '{0, 1, 3, 0};

    tx_packet_arbiter #(
        .NUM_SRC (4),
        .DATA_W  (8),
        .TID_W   (3)
    ) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .src_enable       (src_enable),
        .s_packet_tvalid  (s_packet_tvalid),
        .s_packet_tready  (s_packet_tready),
        .s_packet_tdata   (s_packet_tdata),
        .s_packet_tlast   (s_packet_tlast),
        .s_packet_tid     (s_packet_tid),
        .tx_packet_tvalid (tx_packet_tvalid),
        .tx_packet_tready (tx_packet_tready),
        .tx_packet_tdata  (tx_packet_tdata),
        .tx_packet_tlast  (tx_packet_tlast),
        .tx_packet_tid    (tx_packet_tid),
        .grant            (grant),
        .busy             (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input logic v, input logic [7:0] d,
                           input logic l, input logic [2:0] t);
        s_packet_tvalid[i]        = v;
        s_packet_tdata[i*8 +: 8]  = d;
        s_packet_tlast[i]         = l;
        s_packet_tid[i*3 +: 3]    = t;
    endtask

    task automatic drive_auto();
        for (int i = 0; i < 4; i++) begin
            if (auto_on[i]) begin
                set_src(i, 1'b1, 8'(i*16 + beat[i]), (beat[i] == len[i]-1), 3'(i));
            end
        end
    endtask

    // Advance one clock: note handshakes just before the edge, update model.
    task automatic adv();
        logic [3:0] hs;
        hs = s_packet_tvalid & s_packet_tready;
        @(posedge aclk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (auto_on[i] && hs[i]) beat[i] = (beat[i] + 1) % len[i];
        end
        drive_auto();
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " grant"},  32'(grant), 32'h0);
        chk({tag, " busy"},   32'(busy), 32'h0);
        chk({tag, " tvalid"}, 32'(tx_packet_tvalid), 32'h0);
        chk({tag, " s_tready"}, 32'(s_packet_tready), 32'h0);
        chk({tag, " tdata"},  32'(tx_packet_tdata), 32'h0);
    endtask

    task automatic chk_auto_pkt(input string tag, input int g);
        adv();
        chk({tag, " grant b0"},    32'(grant), 32'(1 << g));
        chk({tag, " busy b0"},     32'(busy), 32'h1);
        chk({tag, " tvalid b0"},   32'(tx_packet_tvalid), 32'h1);
        chk({tag, " tdata b0"},    32'(tx_packet_tdata), 32'(g*16));
        chk({tag, " tid b0"},      32'(tx_packet_tid), 32'(g));
        chk({tag, " tlast b0"},    32'(tx_packet_tlast), 32'h0);
        chk({tag, " s_tready b0"}, 32'(s_packet_tready), 32'(1 << g));
    endtask

    task automatic chk_auto_tail(input string tag, input int g);
        adv();
        chk({tag, " grant b1"}, 32'(grant), 32'(1 << g));
        chk({tag, " tdata b1"}, 32'(tx_packet_tdata), 32'(g*16 + 1));
        chk({tag, " tlast b1"}, 32'(tx_packet_tlast), 32'h1);
        adv();
        chk_idle({tag, " bubble"});
    endtask

    initial begin
        aresetn          = 1'b0;
        src_enable       = 4'b1111;
        s_packet_tvalid  = '0;
        s_packet_tdata   = '0;
        s_packet_tlast   = '0;
        s_packet_tid     = '0;
        tx_packet_tready = 1'b1;
        auto_on          = '0;
        for (int i = 0; i < 4; i++) begin
            beat[i] = 0;
            len[i]  = 2;
        end

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        chk_idle("reset");
        chk("reset tlast", 32'(tx_packet_tlast), 32'h0);
        chk("reset tid",   32'(tx_packet_tid), 32'h0);
        aresetn = 1'b1;

        // Single source: src 2, beats 11/22/33, tid 5
        set_src(2, 1'b1, 8'h11, 1'b0, 3'd5);
        #1;
        chk("t1 idle tvalid", 32'(tx_packet_tvalid), 32'h0);
        chk("t1 idle s_tready", 32'(s_packet_tready), 32'h0);
        adv();
        chk("t1 grant",   32'(grant), 32'h4);
        chk("t1 busy",    32'(busy), 32'h1);
        chk("t1 tvalid",  32'(tx_packet_tvalid), 32'h1);
        chk("t1 tdata0",  32'(tx_packet_tdata), 32'h11);
        chk("t1 tid0",    32'(tx_packet_tid), 32'h5);
        chk("t1 tlast0",  32'(tx_packet_tlast), 32'h0);
        chk("t1 s_tready", 32'(s_packet_tready), 32'h4);
        adv();
        set_src(2, 1'b1, 8'h22, 1'b0, 3'd5);
        #1;
        chk("t1 tdata1",  32'(tx_packet_tdata), 32'h22);
        chk("t1 grant1",  32'(grant), 32'h4);
        adv();
        set_src(2, 1'b1, 8'h33, 1'b1, 3'd5);
        #1;
        chk("t1 tdata2",  32'(tx_packet_tdata), 32'h33);
        chk("t1 tlast2",  32'(tx_packet_tlast), 32'h1);
        chk("t1 tid2",    32'(tx_packet_tid), 32'h5);
        adv();
        set_src(2, 1'b0, 8'h00, 1'b0, 3'd0);
        #1;
        chk_idle("t1 end");

        // Wrap: rr_ptr=3, src 0 and 3 request together -> 3 then 0
        set_src(0, 1'b1, 8'hA0, 1'b1, 3'd1);
        set_src(3, 1'b1, 8'hD3, 1'b1, 3'd3);
        #1;
        adv();
        chk("wrap grant3", 32'(grant), 32'h8);
        chk("wrap tdata3", 32'(tx_packet_tdata), 32'hD3);
        chk("wrap tid3",   32'(tx_packet_tid), 32'h3);
        chk("wrap tlast3", 32'(tx_packet_tlast), 32'h1);
        adv();
        set_src(3, 1'b0, 8'h00, 1'b0, 3'd0);
        #1;
        chk_idle("wrap bubble");
        adv();
        chk("wrap grant0", 32'(grant), 32'h1);
        chk("wrap tdata0", 32'(tx_packet_tdata), 32'hA0);
        chk("wrap tid0",   32'(tx_packet_tid), 32'h1);
        adv();
        set_src(0, 1'b0, 8'h00, 1'b0, 3'd0);
        #1;
        chk_idle("wrap end");

        // Backpressure: rr_ptr=1 so src 1 wins over src 0 and 3
        set_src(0, 1'b1, 8'h0A, 1'b0, 3'd0);
        set_src(1, 1'b1, 8'hB1, 1'b0, 3'd2);
        set_src(3, 1'b1, 8'h3A, 1'b0, 3'd0);
        #1;
        adv();
        chk("bp grant",    32'(grant), 32'h2);
        chk("bp tdata b1", 32'(tx_packet_tdata), 32'hB1);
        chk("bp s_tready hi", 32'(s_packet_tready), 32'h2);
        adv();
        set_src(1, 1'b1, 8'hB2, 1'b0, 3'd2);
        tx_packet_tready = 1'b0;
        #1;
        chk("bp s_tready stall1", 32'(s_packet_tready), 32'h0);
        chk("bp tdata stall1",    32'(tx_packet_tdata), 32'hB2);
        chk("bp tvalid stall1",   32'(tx_packet_tvalid), 32'h1);
        adv();
        chk("bp s_tready stall2", 32'(s_packet_tready), 32'h0);
        chk("bp tdata stall2",    32'(tx_packet_tdata), 32'hB2);
        chk("bp grant stall2",    32'(grant), 32'h2);
        adv();
        tx_packet_tready = 1'b1;
        #1;
        chk("bp s_tready resume", 32'(s_packet_tready), 32'h2);
        chk("bp tdata resume",    32'(tx_packet_tdata), 32'hB2);
        adv();
        set_src(1, 1'b1, 8'hB3, 1'b1, 3'd2);
        #1;
        chk("bp tdata b3", 32'(tx_packet_tdata), 32'hB3);
        chk("bp tlast b3", 32'(tx_packet_tlast), 32'h1);
        adv();
        set_src(0, 1'b0, 8'h00, 1'b0, 3'd0);
        set_src(1, 1'b0, 8'h00, 1'b0, 3'd0);
        set_src(3, 1'b0, 8'h00, 1'b0, 3'd0);
        #1;
        chk_idle("bp end");

        // Reset during beat 2 of a 4-beat packet from src 2
        len[2]  = 4;
        beat[2] = 0;
        auto_on = 4'b0100;
        drive_auto();
        #1;
        adv();
        chk("rst grant", 32'(grant), 32'h4);
        chk("rst tdata b0", 32'(tx_packet_tdata), 32'h20);
        adv();
        chk("rst tdata b1", 32'(tx_packet_tdata), 32'h21);
        adv();
        aresetn = 1'b0;
        #1;
        chk("rst tdata b2", 32'(tx_packet_tdata), 32'h22);
        chk("rst tvalid b2", 32'(tx_packet_tvalid), 32'h1);
        adv();
        aresetn = 1'b1;
        auto_on = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            beat[i] = 0;
            len[i]  = 2;
        end
        drive_auto();
        #1;
        chk_idle("rst after");
        chk("rst after tlast", 32'(tx_packet_tlast), 32'h0);

        // Fairness: all four requesting, rr_ptr=0 after reset
        for (int p = 0; p < 5; p++) begin
            chk_auto_pkt($sformatf("fair p%0d", p), order_fair[p]);
            chk_auto_tail($sformatf("fair p%0d", p), order_fair[p]);
        end

        // Mask: reset pointer, enable 1011, then drop bit 1 mid-packet
        aresetn    = 1'b0;
        src_enable = 4'b1011;
        #1;
        adv();
        aresetn = 1'b1;
        #1;
        chk_idle("mask start");
        for (int p = 0; p < 4; p++) begin
            chk_auto_pkt($sformatf("mask p%0d", p), order_mask[p]);
            if (p == 1) begin
                src_enable = 4'b1001;
                #1;
            end
            chk_auto_tail($sformatf("mask p%0d", p), order_mask[p]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
